dflipflop_bank: RTL and testbench
=================================

// Module: dflipflop_bank
// PURPOSE
//   Parametrised D-register bank: WIDTH D flip-flops sharing one clock, with Q and Q-bar outputs.
//   Generalises the single D flip-flop with preset/clear. Adds:
//     - synchronous preset/clear
//     - clock enable
//     - parallel load, shift left, shift right, and hold modes
//     - serial in/out at both ends
//   Used as the storage/shift primitive behind generated register, counter and shift-register circuits.
// PARAMETERS
//   WIDTH         8          number of flip-flops (>= 2)
//   RESET_VALUE   {WIDTH{0}} q value forced by asynchronous reset
//   PRESET_VALUE  {WIDTH{1}} q value loaded by synchronous preset
// PORTS
//   input_clock_clk   in   1      rising-edge clock
//   input_reset_n     in   1      asynchronous reset, active-low
//   en                in   1      clock enable for mode operations
//   clear             in   1      synchronous clear, active-high
//   preset            in   1      synchronous preset, active-high
//   mode              in   2      00 hold, 01 load, 10 shift left, 11 shift right
//   d                 in   WIDTH  parallel load data
//   ser_in_l          in   1      serial input entering at MSB (shift right)
//   ser_in_r          in   1      serial input entering at LSB (shift left)
//   q                 out  WIDTH  register state
//   q_n               out  WIDTH  bitwise complement of q, always ~q
//   ser_out_l         out  1      q[WIDTH-1]
//   ser_out_r         out  1      q[0]
//   changed           out  1      one-cycle pulse: q changed on the last edge
// BEHAVIOUR
//   - Reset: input_reset_n=0 acts immediately, independent of the clock.
//       q=RESET_VALUE, q_n=~RESET_VALUE, changed=0.
//       Reset held overrides all inputs.
//   - Reset release: synchronous use of input_reset_n is not required.
//       First active edge after release evaluates inputs normally.
//   - Per rising edge, priority clear > preset > en:
//       - clear=1:            q<=0 (regardless of preset, en, mode)
//       - else preset=1:      q<=PRESET_VALUE
//       - else en=0:          hold
//       - else mode 00:       hold
//       - else mode 01:       q<=d
//       - else mode 10:       q<={q[WIDTH-2:0],ser_in_r}; old q[WIDTH-1] lost
//       - else mode 11:       q<={ser_in_l,q[WIDTH-1:1]}; old q[0] lost
//   - Latency: one edge, input to q. q_n, ser_out_l, ser_out_r are combinational from q (no extra cycle).
//   - changed: registered. changed<=(q_next!=q) on every edge, so it is high for exactly the cycle after q changes.
//       Loading or presetting an identical value gives changed=0.
//   - Serial chaining: two banks may be cascaded, ser_out_l -> ser_in_r.
//       Both banks shift on the same edge with no bubble.
//   - No X propagation: mode is fully decoded; no unassigned case.
// CONFIGURATION
//   Macro DFF_BANK_PARITY_EN.
//   - Defined:
//       - adds output port parity (out, 1) = registered even parity (XOR) of q.
//       - Computed from q_next, so it is valid in the same cycle as q.
//       - Reset value is ^RESET_VALUE.
//   - Undefined: no parity port, no parity logic; the rest is unchanged.
// TESTING   (WIDTH=8, default parameters)
//   - Reset: input_reset_n=0 mid-cycle while q=8'hA5 -> q=8'h00, q_n=8'hFF and changed=0 before the next edge.
//   - Load: mode=01, en=1, d=8'h3C -> after 1 edge q=8'h3C, q_n=8'hC3, changed=1.
//       Same d again -> changed=0.
//   - Shift left: q=8'h81, mode=10, ser_in_r=1, 3 edges -> q=8'h0F, ser_out_l=0.
//   - Shift right: q=8'h81, mode=11, ser_in_l=0, 1 edge -> q=8'h40, ser_out_r=0.
//   - Priority: clear=1, preset=1, en=1, mode=01, d=8'h55 -> q=8'h00.
//       Then clear=0 -> q=8'hFF.
//       Then en=0, mode=01 -> q holds 8'hFF.
//   - Parity (DFF_BANK_PARITY_EN defined): load 8'h07 -> parity=1 on the same edge; load 8'h03 -> parity=0.

Source files
------------

// File: rtl/dflipflop_bank.sv
// Parametrised D-register bank with sync clear/preset, clock enable, load/shift modes and a change pulse.
// Optional registered even-parity output is enabled by defining DFF_BANK_PARITY_EN.
module dflipflop_bank #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
   input  logic             input_clock_clk,
   input  logic             input_reset_n,
   input  logic             en,
   input  logic             clear,
   input  logic             preset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             ser_out_l,
   output logic             ser_out_r,
`ifdef DFF_BANK_PARITY_EN
   output logic             parity,
`endif
   output logic             changed
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_SHL   = 2'b10,
      MODE_SHR   = 2'b11
   } mode_e;

   logic [WIDTH-1:0] r_q;
   logic             r_changed;
   logic [WIDTH-1:0] w_q_next;
   mode_e            w_mode;

   assign w_mode = mode_e'(mode);

   // Priority: clear beats preset, preset beats the enabled mode operation.
   always_comb begin
      // NOTE: default assignment first so every path drives w_q_next and no latch is inferred.
      w_q_next = r_q;
      if (clear) begin
         w_q_next = '0;
      end else if (preset) begin
         w_q_next = PRESET_VALUE;
      end else if (en) begin
         unique case (w_mode)
            MODE_HOLD: w_q_next = r_q;
            MODE_LOAD: w_q_next = d;
            MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  w_q_next = {ser_in_l, r_q[WIDTH-1:1]};
         endcase
      end
   end

   always_ff @(posedge input_clock_clk or negedge input_reset_n) begin
      if (!input_reset_n) begin
         r_q       <= RESET_VALUE;
         r_changed <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers sample pre-edge values together.
         r_q       <= w_q_next;
         r_changed <= (w_q_next != r_q);
      end
   end

`ifdef DFF_BANK_PARITY_EN
   logic r_parity;

   // Registered alongside q from the same next-state, so it never lags q.
   always_ff @(posedge input_clock_clk or negedge input_reset_n) begin
      if (!input_reset_n) begin
         r_parity <= ^RESET_VALUE;
      end else begin
         r_parity <= ^w_q_next;
      end
   end

   assign parity = r_parity;
`endif

   assign q         = r_q;
   assign q_n       = ~r_q;
   assign ser_out_l = r_q[WIDTH-1];
   assign ser_out_r = r_q[0];
   assign changed   = r_changed;

endmodule

// File: tb/tb_dflipflop_bank.sv
// Directed-vector bench for dflipflop_bank (WIDTH=8) with an arithmetic reference model checked every cycle.
module tb_dflipflop_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       clear = 1'b0;
   logic       preset = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] d = 8'h00;
   logic       sl = 1'b0;
   logic       sr = 1'b0;
   logic [7:0] q;
   logic [7:0] q_n;
   logic       sol;
   logic       sor;
   logic       changed;
`ifdef DFF_BANK_PARITY_EN
   logic       parity;
`endif

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   dflipflop_bank #(.WIDTH(8)) dut (
      .input_clock_clk(clk),
      .input_reset_n  (rst_n),
      .en             (en),
      .clear          (clear),
      .preset         (preset),
      .mode           (mode),
      .d              (d),
      .ser_in_l       (sl),
      .ser_in_r       (sr),
      .q              (q),
      .q_n            (q_n),
      .ser_out_l      (sol),
      .ser_out_r      (sor),
`ifdef DFF_BANK_PARITY_EN
      .parity         (parity),
`endif
      .changed        (changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: register value as an integer 0..255, updated by arithmetic rules.
   int m_q = 0;
   bit m_ch = 1'b0;

   always @(posedge clk or negedge rst_n) begin : model
      int nxt;
      if (!rst_n) begin
         m_q  <= 0;
         m_ch <= 1'b0;
      end else begin
         nxt = m_q;
         if (clear)       nxt = 0;
         else if (preset) nxt = 255;
         else if (en) begin
            case (mode)
               2'd1: nxt = int'(d);
               2'd2: nxt = (m_q * 2 + int'(sr)) % 256;
               2'd3: nxt = m_q / 2 + int'(sl) * 128;
               default: nxt = m_q;
            endcase
         end
         m_ch <= (nxt != m_q);
         m_q  <= nxt;
      end
   end

   function automatic int popcount_odd(input int v);
      int c = 0;
      for (int i = 0; i < 8; i++) c += (v >> i) & 1;
      return c % 2;
   endfunction

   // Compare process: mid-cycle sampling of every output against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_q",       {24'd0, q},       m_q);
         check("cyc_q_n",     {24'd0, q_n},     255 - m_q);
         check("cyc_ser_l",   {31'd0, sol},     m_q / 128);
         check("cyc_ser_r",   {31'd0, sor},     m_q % 2);
         check("cyc_changed", {31'd0, changed}, {31'd0, m_ch});
`ifdef DFF_BANK_PARITY_EN
         check("cyc_parity",  {31'd0, parity},  popcount_odd(m_q));
`endif
      end
   end

   // Drive one vector, let one edge pass, return shortly after that edge.
   task automatic cyc(input bit c, input bit p, input bit e, input logic [1:0] m,
                      input logic [7:0] dv, input bit l, input bit r);
      clear = c; preset = p; en = e; mode = m; d = dv; sl = l; sr = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("reset_q",       {24'd0, q}, 32'h00);
      check("reset_q_n",     {24'd0, q_n}, 32'hFF);
      check("reset_changed", {31'd0, changed}, 32'd0);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // Load A5, then async reset mid-cycle.
      cyc(0, 0, 1, 2'b01, 8'hA5, 0, 0);
      check("load_a5", {24'd0, q}, 32'hA5);
      check("load_a5_changed", {31'd0, changed}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_q",       {24'd0, q}, 32'h00);
      check("async_rst_q_n",     {24'd0, q_n}, 32'hFF);
      check("async_rst_changed", {31'd0, changed}, 32'd0);
      cyc(0, 1, 1, 2'b01, 8'h3C, 1, 1);
      check("rst_held_q", {24'd0, q}, 32'h00);
      rst_n = 1'b1;

      // Load 3C twice.
      cyc(0, 0, 1, 2'b01, 8'h3C, 0, 0);
      check("load_3c_q",       {24'd0, q}, 32'h3C);
      check("load_3c_q_n",     {24'd0, q_n}, 32'hC3);
      check("load_3c_changed", {31'd0, changed}, 32'd1);
      check("model_3c",        m_q, 32'h3C);
      cyc(0, 0, 1, 2'b01, 8'h3C, 0, 0);
      check("reload_3c_changed", {31'd0, changed}, 32'd0);

      // Shift left 81 with ser_in_r=1 three times.
      cyc(0, 0, 1, 2'b01, 8'h81, 0, 0);
      repeat (3) cyc(0, 0, 1, 2'b10, 8'h00, 0, 1);
      check("shl_q",     {24'd0, q}, 32'h0F);
      check("shl_ser_l", {31'd0, sol}, 32'd0);
      check("model_shl", m_q, 32'h0F);

      // Shift right 81 with ser_in_l=0 once.
      cyc(0, 0, 1, 2'b01, 8'h81, 0, 0);
      cyc(0, 0, 1, 2'b11, 8'h00, 0, 1);
      check("shr_q",     {24'd0, q}, 32'h40);
      check("shr_ser_r", {31'd0, sor}, 32'd0);
      check("model_shr", m_q, 32'h40);

      // Shift right with ser_in_l=1, and shift left dropping the MSB.
      cyc(0, 0, 1, 2'b11, 8'h00, 1, 0);
      check("shr_in1_q", {24'd0, q}, 32'hA0);
      cyc(0, 0, 1, 2'b10, 8'h00, 0, 0);
      check("shl_drop_q", {24'd0, q}, 32'h40);

      // Priority chain.
      cyc(1, 1, 1, 2'b01, 8'h55, 0, 0);
      check("prio_clear_q", {24'd0, q}, 32'h00);
      cyc(0, 1, 1, 2'b01, 8'h55, 0, 0);
      check("prio_preset_q", {24'd0, q}, 32'hFF);
      check("prio_preset_changed", {31'd0, changed}, 32'd1);
      cyc(0, 0, 0, 2'b01, 8'h55, 0, 0);
      check("en_off_hold_q", {24'd0, q}, 32'hFF);
      check("en_off_changed", {31'd0, changed}, 32'd0);
      cyc(0, 1, 1, 2'b10, 8'h00, 0, 0);
      check("preset_same_changed", {31'd0, changed}, 32'd0);
      cyc(0, 0, 1, 2'b00, 8'h12, 1, 1);
      check("mode_hold_q", {24'd0, q}, 32'hFF);
      cyc(1, 0, 0, 2'b00, 8'h00, 0, 0);
      check("clear_en_off_q", {24'd0, q}, 32'h00);
      cyc(0, 0, 0, 2'b10, 8'h00, 0, 1);
      check("shl_en_off_q", {24'd0, q}, 32'h00);

`ifdef DFF_BANK_PARITY_EN
      cyc(0, 0, 1, 2'b01, 8'h07, 0, 0);
      check("parity_07", {31'd0, parity}, 32'd1);
      cyc(0, 0, 1, 2'b01, 8'h03, 0, 0);
      check("parity_03", {31'd0, parity}, 32'd0);
`endif

      // A few more loads to exercise the model against mixed patterns.
      cyc(0, 0, 1, 2'b01, 8'h5A, 0, 0);
      cyc(0, 0, 1, 2'b11, 8'h00, 1, 0);
      check("mix_q", {24'd0, q}, 32'hAD);
      cyc(0, 0, 1, 2'b10, 8'h00, 0, 1);
      check("mix2_q", {24'd0, q}, 32'h5B);

      @(negedge clk);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
